// File: rtl/pupil_detect_stream_if.sv
// pupil_detect_stream_if: pixel stream in, pupil result out
interface pupil_detect_stream_if #(
  parameter int PIX_W   = 8,
  parameter int COORD_W = 8
);
  logic               frame_start;
  logic               pix_valid;
  logic [PIX_W-1:0]   pix_data;
  logic [PIX_W-1:0]   threshold;
  logic [COORD_W-1:0] pupil_x;
  logic [COORD_W-1:0] pupil_y;
  logic [COORD_W-1:0] blob_width;
  logic               result_valid;
  logic               result_found;
  logic               busy;
  modport master (
    output frame_start, pix_valid, pix_data, threshold,
    input  pupil_x, pupil_y, blob_width, result_valid, result_found, busy
  );
  modport slave (
    input  frame_start, pix_valid, pix_data, threshold,
    output pupil_x, pupil_y, blob_width, result_valid, result_found, busy
  );
endinterface

// File: rtl/pupil_detect_stream.sv
// pupil_detect_stream: per-line dark-blob search on a pixel stream, widest blob of the frame wins
module pupil_detect_stream #(
  parameter int IMG_WIDTH  = 112,
  parameter int IMG_HEIGHT = 112,
  parameter int PIX_W      = 8,
  parameter int COORD_W    = 8,
  parameter int MIN_BLOB   = 2,
  parameter int MODE       = 1
) (
  input  logic                  i_clock,
  input  logic                  i_reset_n,
  pupil_detect_stream_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, SEARCH_BEGIN, SEARCH_END, DONE} state_t;
  state_t r_state, w_next;
  logic [COORD_W-1:0] r_col, r_row, r_begin, r_cand_w, r_cand_x, r_max, r_x, r_y;
  logic [COORD_W-1:0] r_px, r_py, r_pw;
  logic [PIX_W-1:0]   r_prev, r_thr;
  logic               r_have, r_found, r_emit, r_busy, r_valid, r_rfound;
  logic signed [PIX_W:0] w_dfall, w_drise, w_thr;
  logic [COORD_W:0]   w_sum;
  logic [COORD_W-1:0] w_blob_w, w_blob_x, w_line_w, w_line_x;
  logic w_acc, w_fall, w_rise, w_line_end, w_hit, w_ok, w_better, w_early, w_finish;
  // nine-bit signed differences keep dark-to-bright and bright-to-dark apart without wrap
  assign w_dfall = $signed({1'b0, r_prev}) - $signed({1'b0, bus.pix_data});
  assign w_drise = $signed({1'b0, bus.pix_data}) - $signed({1'b0, r_prev});
  assign w_thr   = $signed({1'b0, r_thr});
  assign w_sum   = {1'b0, r_begin} + {1'b0, r_col} - 1'b1;
  always_ff @(posedge i_clock or negedge i_reset_n)
    if (!i_reset_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = bus.frame_start ? SEARCH_BEGIN :
             w_finish ? DONE :
             w_line_end ? SEARCH_BEGIN :
             (w_acc && r_state == SEARCH_BEGIN && w_fall) ? SEARCH_END :
             (w_hit && !w_ok) ? SEARCH_BEGIN : r_state;
  end
  always_comb begin
    w_acc      = bus.pix_valid && !bus.frame_start &&
                 (r_state == SEARCH_BEGIN || r_state == SEARCH_END);
    w_fall     = r_col != '0 && w_dfall > w_thr;
    w_rise     = r_col != '0 && w_drise > w_thr;
    w_line_end = w_acc && r_col == COORD_W'(IMG_WIDTH - 1);
    w_blob_w   = r_col - r_begin;
    w_blob_x   = COORD_W'(w_sum >> 1);
    w_hit      = w_acc && r_state == SEARCH_END && !r_have && w_rise;
    w_ok       = w_hit && w_blob_w >= COORD_W'(MIN_BLOB);
    w_line_w   = w_ok ? w_blob_w : (r_have ? r_cand_w : '0);
    w_line_x   = w_ok ? w_blob_x : r_cand_x;
    w_better   = w_line_w > r_max;
    w_early    = MODE == 0 && r_found && w_line_w < r_max;
    w_finish   = w_line_end && (r_row == COORD_W'(IMG_HEIGHT - 1) || w_early);
  end
  always_ff @(posedge i_clock or negedge i_reset_n)
    if (!i_reset_n) begin
      r_col    <= '0;
      r_row    <= '0;
      r_begin  <= '0;
      r_cand_w <= '0;
      r_cand_x <= '0;
      r_max    <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_prev   <= '0;
      r_thr    <= '0;
      r_have   <= 1'b0;
      r_found  <= 1'b0;
      r_emit   <= 1'b0;
      r_busy   <= 1'b0;
      r_valid  <= 1'b0;
      r_rfound <= 1'b0;
      r_px     <= '0;
      r_py     <= '0;
      r_pw     <= '0;
    end else begin
      r_valid <= 1'b0;
      if (bus.frame_start) begin
        r_col   <= bus.pix_valid ? COORD_W'(1) : '0;
        r_row   <= '0;
        r_prev  <= bus.pix_data;
        r_thr   <= bus.threshold;
        r_max   <= '0;
        r_found <= 1'b0;
        r_have  <= 1'b0;
        r_emit  <= 1'b0;
        r_busy  <= 1'b1;
      end else begin
        // the result is published one cycle after the finishing pixel
        if (r_emit) begin
          r_emit   <= 1'b0;
          r_busy   <= 1'b0;
          r_valid  <= 1'b1;
          r_rfound <= r_found;
          if (r_found) begin
            r_px <= r_x;
            r_py <= r_y;
            r_pw <= r_max;
          end
        end
        if (w_acc) begin
          r_prev <= bus.pix_data;
          r_col  <= w_line_end ? '0 : r_col + 1'b1;
          if (r_state == SEARCH_BEGIN && w_fall) r_begin <= r_col;
          if (w_line_end) begin
            r_row  <= r_row + 1'b1;
            r_have <= 1'b0;
            r_emit <= w_finish;
            if (w_better) begin
              r_max   <= w_line_w;
              r_x     <= w_line_x;
              r_y     <= r_row;
              r_found <= 1'b1;
            end
          end else if (w_ok) begin
            r_have   <= 1'b1;
            r_cand_w <= w_blob_w;
            r_cand_x <= w_blob_x;
          end
        end
      end
    end
  assign bus.pupil_x      = r_px;
  assign bus.pupil_y      = r_py;
  assign bus.blob_width   = r_pw;
  assign bus.result_valid = r_valid;
  assign bus.result_found = r_rfound;
  assign bus.busy         = r_busy;
endmodule

// File: tb/tb_pupil_detect_stream.sv
// tb_pupil_detect_stream: MODE 0 and MODE 1 detectors fed the same frames, checked against a frame model
module tb_pupil_detect_stream;
  localparam int W = 112, H = 112, PW = 8, CW = 8, MINB = 2;
  logic clk = 1'b0, rst_n = 1'b0;
  logic fs, pv;
  logic [PW-1:0] pd, thr;
  always #5 clk = ~clk;
  pupil_detect_stream_if #(.PIX_W(PW), .COORD_W(CW)) if0 ();
  pupil_detect_stream_if #(.PIX_W(PW), .COORD_W(CW)) if1 ();
  assign if0.frame_start = fs;
  assign if0.pix_valid   = pv;
  assign if0.pix_data    = pd;
  assign if0.threshold   = thr;
  assign if1.frame_start = fs;
  assign if1.pix_valid   = pv;
  assign if1.pix_data    = pd;
  assign if1.threshold   = thr;
  pupil_detect_stream #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(PW), .COORD_W(CW), .MIN_BLOB(MINB), .MODE(0))
    u0 (.i_clock(clk), .i_reset_n(rst_n), .bus(if0.slave));
  pupil_detect_stream #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(PW), .COORD_W(CW), .MIN_BLOB(MINB), .MODE(1))
    u1 (.i_clock(clk), .i_reset_n(rst_n), .bus(if1.slave));
  logic [CW-1:0] ax[2], ay[2], aw[2];
  logic av[2], af[2], ab[2];
  assign ax[0] = if0.pupil_x;      assign ax[1] = if1.pupil_x;
  assign ay[0] = if0.pupil_y;      assign ay[1] = if1.pupil_y;
  assign aw[0] = if0.blob_width;   assign aw[1] = if1.blob_width;
  assign av[0] = if0.result_valid; assign av[1] = if1.result_valid;
  assign af[0] = if0.result_found; assign af[1] = if1.result_found;
  assign ab[0] = if0.busy;         assign ab[1] = if1.busy;
  logic [PW-1:0] img [H][W];
  int cyc = 0, n_chk = 0, n_err = 0, fs_cyc = -1;
  int exp_cyc[2] = '{-1, -1};
  int fin_row[2], px[2], py[2], pw[2], ex[2], ey[2], ew[2];
  bit pf[2], ef[2], eb[2];
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input int m, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s dut%0d: got %0d want %0d (cycle %0d)", nm, m, act, want, cyc);
    end
  endtask
  // expected outputs advance on the cycle the model says the result lands
  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      bit ev;
      ev = 1'b0;
      if (!rst_n) begin
        ex[m] = 0; ey[m] = 0; ew[m] = 0; ef[m] = 1'b0; eb[m] = 1'b0;
      end else begin
        if (cyc == fs_cyc) eb[m] = 1'b1;
        if (cyc == exp_cyc[m]) begin
          eb[m] = 1'b0;
          ev = 1'b1;
          ef[m] = pf[m];
          if (pf[m]) begin ex[m] = px[m]; ey[m] = py[m]; ew[m] = pw[m]; end
        end
      end
      chk("result_valid", m, 32'(av[m]), 32'(ev));
      chk("busy", m, 32'(ab[m]), 32'(eb[m]));
      chk("pupil_x", m, 32'(ax[m]), 32'(ex[m]));
      chk("pupil_y", m, 32'(ay[m]), 32'(ey[m]));
      chk("blob_width", m, 32'(aw[m]), 32'(ew[m]));
      chk("result_found", m, 32'(af[m]), 32'(ef[m]));
    end
  end
  task automatic scan_line(input int r, input int t, output int w, output int x);
    int c, b, e;
    w = 0; x = 0; c = 1;
    while (c < W) begin
      b = -1;
      for (int k = c; k < W; k++) if (b < 0 && int'(img[r][k-1]) - int'(img[r][k]) > t) b = k;
      if (b < 0) return;
      e = -1;
      for (int k = b + 1; k < W; k++) if (e < 0 && int'(img[r][k]) - int'(img[r][k-1]) > t) e = k;
      if (e < 0) return;
      if (e - b >= MINB) begin w = e - b; x = (b + e - 1) / 2; return; end
      c = e + 1;
    end
  endtask
  task automatic model(input int t);
    for (int m = 0; m < 2; m++) begin
      int mx, w, x;
      mx = 0; pf[m] = 1'b0; fin_row[m] = H - 1;
      for (int r = 0; r < H; r++) begin
        scan_line(r, t, w, x);
        if (w > mx) begin
          mx = w; px[m] = x; py[m] = r; pw[m] = w; pf[m] = 1'b1;
        end else if (m == 0 && pf[m] && w < mx) begin
          fin_row[m] = r;
          break;
        end
      end
    end
  endtask
  task automatic fill(input logic [PW-1:0] v);
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = v;
  endtask
  task automatic dark(input int r, input int c0, input int c1, input logic [PW-1:0] v);
    for (int c = c0; c <= c1; c++) img[r][c] = v;
  endtask
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; fs = 1'b0; pv = 1'b0; end
  endtask
  // threshold is scrambled after frame_start so only the latched value may matter
  task automatic send_frame(input int t, input int abort_row, input int g0, input int g1);
    model(t);
    for (int r = 0; r < H; r++) begin
      if (r == abort_row) return;
      for (int c = 0; c < W; c++) begin
        @(posedge clk); #1;
        fs = (r == 0 && c == 0);
        thr = fs ? PW'(t) : 8'd250;
        if (fs) fs_cyc = cyc + 1;
        pv = 1'b1;
        pd = img[r][c];
        for (int m = 0; m < 2; m++) if (r == fin_row[m] && c == W - 1) exp_cyc[m] = cyc + 2;
        if (r >= g0 && r <= g1) idle(3);
      end
    end
    idle(1);
  endtask
  task automatic lit(input int m, input int x, input int y, input int w, input int f);
    chk("lit_x", m, 32'(ax[m]), x);
    chk("lit_y", m, 32'(ay[m]), y);
    chk("lit_w", m, 32'(aw[m]), w);
    chk("lit_found", m, 32'(af[m]), f);
  endtask
  task automatic image_a();
    fill(8'd200);
    for (int r = 30; r <= 50; r++) dark(r, 40, 59, 8'd20);
  endtask
  initial begin
    fs = 1'b0; pv = 1'b0; pd = '0; thr = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    image_a();
    send_frame(80, -1, -1, -1);
    idle(4);
    lit(1, 49, 30, 20, 1);
    lit(0, 49, 30, 20, 1);
    send_frame(80, 5, -1, -1);
    @(posedge clk); #1;
    rst_n = 1'b0; fs_cyc = -1; exp_cyc[0] = -1; exp_cyc[1] = -1; fs = 1'b0; pv = 1'b1; pd = 8'd20;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int r = 5; r < 10; r++)
      for (int c = 0; c < W; c++) begin @(posedge clk); #1; pv = 1'b1; pd = img[r][c]; end
    idle(4);
    lit(1, 0, 0, 0, 0);
    lit(0, 0, 0, 0, 0);
    fill(8'd200);
    dark(10, 40, 49, 8'd20);
    dark(11, 40, 51, 8'd20);
    dark(12, 40, 53, 8'd20);
    dark(13, 40, 47, 8'd20);
    dark(60, 40, 69, 8'd20);
    send_frame(80, -1, -1, -1);
    idle(4);
    lit(0, 46, 12, 14, 1);
    lit(1, 54, 60, 30, 1);
    fill(8'd10);
    img[0][1] = 8'd250;
    dark(1, 50, 54, 8'd60);
    dark(1, 55, W - 1, 8'd200);
    send_frame(80, -1, -1, -1);
    idle(4);
    lit(0, 46, 12, 14, 0);
    lit(1, 54, 60, 30, 0);
    fill(8'd200);
    img[7][20] = 8'd20;
    dark(7, 70, 75, 8'd20);
    send_frame(80, -1, -1, -1);
    idle(4);
    lit(0, 72, 7, 6, 1);
    lit(1, 72, 7, 6, 1);
    image_a();
    send_frame(80, 40, -1, -1);
    send_frame(80, -1, 28, 34);
    idle(4);
    lit(0, 49, 30, 20, 1);
    lit(1, 49, 30, 20, 1);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
